// File: rtl/wishbone_cmd_queue.sv
// wishbone_cmd_queue: Wishbone-mapped command FIFO feeding the enclave core and result FIFO drained by bus reads.
// Define WB_CMD_QUEUE_ERR_EN to implement the sticky cmd_overflow/res_underflow STATUS bits.
module wishbone_cmd_queue #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CMD_DEPTH = 8,
    parameter int          RES_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wishbone_data,
    input  logic [31:0] wishbone_addr,
    input  logic        wb_write_req,
    input  logic        wb_read_req,
    output logic [31:0] wishbone_output,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_is_op_o,
    output logic [31:0] cmd_data_o,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    input  logic [31:0] res_data_i
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [31:0] OPC_ADDR = BASE_ADDR;
    localparam logic [31:0] OPR_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0] STS_ADDR = BASE_ADDR + 32'h8;
    localparam logic [31:0] RES_ADDR = BASE_ADDR + 32'hC;

    logic [32:0]    cmd_mem [CMD_DEPTH];
    logic [31:0]    res_mem [RES_DEPTH];
    logic [CAW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
    logic [RAW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [RAW:0]   res_cnt_q, res_cnt_d;
    logic           wr_q, wr_d;
    logic           cmd_full, cmd_pop, cmd_push, cmd_push_req;
    logic           res_empty, res_pop, res_push, res_rd;
    logic           cmd_ovf, res_unf;
    logic [31:0]    status, res_head;

    always_comb begin
        wr_d         = wb_write_req;
        cmd_full     = cmd_cnt_q == (CAW+1)'(CMD_DEPTH);
        cmd_valid_o  = cmd_cnt_q != '0;
        cmd_pop      = cmd_valid_o & cmd_ready_i;
        cmd_push_req = wr_q & (wishbone_addr == OPC_ADDR || wishbone_addr == OPR_ADDR);
        // A full FIFO still takes the word when the head leaves in the same cycle.
        cmd_push     = cmd_push_req & (~cmd_full | cmd_pop);
        cmd_wp_d     = cmd_push ? cmd_wp_q + CAW'(1) : cmd_wp_q;
        cmd_rp_d     = cmd_pop ? cmd_rp_q + CAW'(1) : cmd_rp_q;
        cmd_cnt_d    = cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
        cmd_is_op_o  = cmd_valid_o ? cmd_mem[cmd_rp_q][32] : 1'b0;
        cmd_data_o   = cmd_valid_o ? cmd_mem[cmd_rp_q][31:0] : 32'h0;
        res_empty    = res_cnt_q == '0;
        res_ready_o  = res_cnt_q < (RAW+1)'(RES_DEPTH);
        res_push     = res_valid_i & res_ready_o;
        res_rd       = wb_read_req & (wishbone_addr == RES_ADDR);
        res_pop      = res_rd & ~res_empty;
        res_wp_d     = res_push ? res_wp_q + RAW'(1) : res_wp_q;
        res_rp_d     = res_pop ? res_rp_q + RAW'(1) : res_rp_q;
        res_cnt_d    = res_cnt_q + (RAW+1)'(res_push) - (RAW+1)'(res_pop);
        res_head     = res_empty ? 32'h0 : res_mem[res_rp_q];
        status       = {6'h0, res_unf, cmd_ovf, 6'h0, res_empty, cmd_full, 8'(res_cnt_q), 8'(cmd_cnt_q)};
        wishbone_output = wishbone_addr == STS_ADDR ? status :
                          wishbone_addr == RES_ADDR ? res_head : 32'h0;
    end

`ifdef WB_CMD_QUEUE_ERR_EN
    logic cmd_ovf_q, cmd_ovf_d, res_unf_q, res_unf_d, sts_wr;
    // Set terms are OR-ed in last so a simultaneous set beats the W1C clear.
    always_comb begin
        sts_wr    = wr_q & (wishbone_addr == STS_ADDR);
        cmd_ovf_d = (cmd_ovf_q & ~(sts_wr & wishbone_data[24])) | (cmd_push_req & ~cmd_push);
        res_unf_d = (res_unf_q & ~(sts_wr & wishbone_data[25])) | (res_rd & res_empty);
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmd_ovf_q <= 1'b0;
            res_unf_q <= 1'b0;
        end else begin
            cmd_ovf_q <= cmd_ovf_d;
            res_unf_q <= res_unf_d;
        end
    end
    assign cmd_ovf = cmd_ovf_q;
    assign res_unf = res_unf_q;
`else
    assign cmd_ovf = 1'b0;
    assign res_unf = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_q      <= 1'b0;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            wr_q      <= wr_d;
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // Storage needs no reset: counts gate every read of it.
    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) cmd_mem[cmd_wp_q] <= {wishbone_addr == OPC_ADDR, wishbone_data};
        if (res_push) res_mem[res_wp_q] <= res_data_i;
    end
endmodule

// File: tb/tb_wishbone_cmd_queue.sv
// tb_wishbone_cmd_queue: scoreboard bench for wishbone_cmd_queue at default parameters.
module tb_wishbone_cmd_queue;
    localparam logic [31:0] OPC = 32'h3000_0000;
    localparam logic [31:0] OPR = 32'h3000_0004;
    localparam logic [31:0] STS = 32'h3000_0008;
    localparam logic [31:0] RES = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wishbone_data = '0, wishbone_addr = '0, res_data_i = '0;
    logic        wb_write_req = 1'b0, wb_read_req = 1'b0, cmd_ready_i = 1'b0, res_valid_i = 1'b0;
    logic [31:0] wishbone_output, cmd_data_o;
    logic        cmd_valid_o, cmd_is_op_o, res_ready_o;

    int total = 0, bad = 0;
    logic [32:0] exp_cmd[$];
    logic [31:0] exp_res[$];
    logic e_ovf = 1'b0, e_unf = 1'b0;

    wishbone_cmd_queue dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wishbone_data(wishbone_data),
        .wishbone_addr(wishbone_addr), .wb_write_req(wb_write_req), .wb_read_req(wb_read_req),
        .wishbone_output(wishbone_output), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_is_op_o(cmd_is_op_o), .cmd_data_o(cmd_data_o), .res_valid_i(res_valid_i),
        .res_ready_o(res_ready_o), .res_data_i(res_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[7:0]  = 8'(exp_cmd.size());
        s[15:8] = 8'(exp_res.size());
        s[16]   = exp_cmd.size() == 8;
        s[17]   = exp_res.size() == 0;
`ifdef WB_CMD_QUEUE_ERR_EN
        s[24]   = e_ovf;
        s[25]   = e_unf;
`endif
        return s;
    endfunction

    // Core-side consumer: every accepted head must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && cmd_valid_o && cmd_ready_i) begin
            if (exp_cmd.size() == 0) check("cmd_pop_unexpected", 1, 0);
            else check("cmd_head", {cmd_is_op_o, cmd_data_o}, exp_cmd.pop_front());
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic pop);
        wishbone_addr = a;
        wishbone_data = 32'hDEAD_BEEF;
        wb_write_req  = 1'b1;
        tick();
        wb_write_req  = 1'b0;
        wishbone_data = d;
        if (exp_cmd.size() == 0) check("cmd_valid_early", cmd_valid_o, 0);
        cmd_ready_i   = pop;
        tick();
        cmd_ready_i   = 1'b0;
        if (a == OPC || a == OPR) begin
            if (exp_cmd.size() < 8) exp_cmd.push_back({a == OPC, d});
            else e_ovf = 1'b1;
        end else if (a == STS) begin
            if (d[24]) e_ovf = 1'b0;
            if (d[25]) e_unf = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input string tag);
        logic [31:0] exp;
        wishbone_addr = a;
        wb_read_req   = 1'b1;
        #1;
        if (a == STS) exp = exp_status();
        else if (a == RES) begin
            if (exp_res.size() == 0) begin
                exp   = 32'h0;
                e_unf = 1'b1;
            end else exp = exp_res.pop_front();
        end else exp = 32'h0;
        check(tag, wishbone_output, exp);
        tick();
        wb_read_req = 1'b0;
    endtask

    task automatic core_push(input logic [31:0] v);
        check("res_ready", res_ready_o, exp_res.size() < 4);
        res_valid_i = 1'b1;
        res_data_i  = v;
        tick();
        res_valid_i = 1'b0;
        if (exp_res.size() < 4) exp_res.push_back(v);
    endtask

    task automatic cmd_pop_one();
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_valid", cmd_valid_o, 0);
        check("rst_res_ready", res_ready_o, 1);
        exp_cmd.delete();
        exp_res.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_status_raw", wishbone_output, 32'h0);
        bus_read(STS, "reset_status");
        check("reset_status_const", exp_status(), 32'h0002_0000);
        check("reset_cmd_valid", cmd_valid_o, 0);
        check("reset_cmd_data", {cmd_is_op_o, cmd_data_o}, 33'h0);
        check("reset_res_ready", res_ready_o, 1);

        bus_write(OPC, 32'hA5, 1'b0);
        check("valid_after_write", cmd_valid_o, 1);
        bus_write(OPR, 32'h1234, 1'b0);
        check("head_opcode", {cmd_is_op_o, cmd_data_o}, {1'b1, 32'hA5});
        cmd_pop_one();
        check("head_operand", {cmd_is_op_o, cmd_data_o}, {1'b0, 32'h1234});
        cmd_pop_one();
        check("drained_valid", cmd_valid_o, 0);

        for (int i = 0; i < 9; i++) bus_write(i[0] ? OPR : OPC, 32'h100 + i, 1'b0);
        bus_read(STS, "status_full_ovf");
        bus_write(STS, 32'h0100_0000, 1'b0);
        bus_read(STS, "status_ovf_cleared");

        bus_write(OPR, 32'h77, 1'b1);
        bus_read(STS, "status_full_push_pop");
        bus_write(OPC, 32'h88, 1'b0);
        bus_read(STS, "status_full_drop");

        core_push(32'h11);
        core_push(32'h22);
        bus_read(STS, "status_res2");
        bus_read(RES, "res_read_11");
        bus_read(STS, "status_res1");
        bus_read(RES, "res_read_22");
        bus_read(STS, "status_res0");
        bus_read(RES, "res_read_empty");
        bus_read(STS, "status_unf");
        bus_write(STS, 32'h0200_0000, 1'b0);
        bus_read(STS, "status_unf_cleared");

        for (int i = 0; i < 5; i++) core_push(32'hC0 + i);
        check("res_ready_full", res_ready_o, 0);
        bus_read(32'h3000_0010, "unmapped_read");
        for (int i = 0; i < 5; i++) bus_read(RES, "res_drain");

        while (exp_cmd.size() > 0) cmd_pop_one();
        for (int i = 0; i < 3; i++) bus_write(OPC, 32'h500 + i, 1'b0);
        check("three_queued", cmd_valid_o, 1);
        async_reset();
        bus_read(STS, "status_after_reset");

        wishbone_addr = OPC;
        wb_write_req  = 1'b1;
        tick();
        wb_write_req  = 1'b0;
        async_reset();
        check("pending_write_dropped", cmd_valid_o, 0);
        bus_read(STS, "status_after_pending_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wishbone_cmd_queue.md
# wishbone_cmd_queue

Command/result buffering stage directly downstream of the Wishbone slave controller. Consumes its registered write data/address and read/write request strobes, decodes a small memory-mapped window, and queues opcode/operand words into a command FIFO for the enclave compute core. It also drains a result FIFO filled by the core back onto the bus, and provides the read data returned on `wbs_dat_o`.

## Interface
- `BASE_ADDR`, 32'h3000_0000: window base. Offsets: +0x0 OPCODE (W), +0x4 OPERAND (W), +0x8 STATUS (R, W1C), +0xC RESULT (R, pops).
- `CMD_DEPTH`, 8: command FIFO entries; power of 2, 2..128.
- `RES_DEPTH`, 4: result FIFO entries; power of 2, 2..128.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: reset; asynchronous, active-low.
- `wishbone_data` in 32: registered write data from the controller; valid the cycle after `wb_write_req`.
- `wishbone_addr` in 32: registered bus address from the controller.
- `wb_write_req` in 1: write strobe, one cycle per bus write.
- `wb_read_req` in 1: read strobe, one cycle per bus read.
- `wishbone_output` out 32: read data, combinational from `wishbone_addr` and FIFO/status state.
- `cmd_valid_o` out 1: command FIFO head valid.
- `cmd_ready_i` in 1: core accepts head.
- `cmd_is_op_o` out 1: head entry is an opcode (1) or operand (0).
- `cmd_data_o` out 32: head entry data.
- `res_valid_i` in 1: core presents result.
- `res_ready_o` out 1: result FIFO not full.
- `res_data_i` in 32: result word.

## Operation
- Write path: `wb_write_req` is registered into `wr_q`. In the `wr_q` cycle, `wishbone_addr`/`wishbone_data` are decoded. OPCODE pushes {1,data}, OPERAND pushes {0,data}, STATUS clears sticky bits where data[25:24]=1. Other addresses are ignored.
- Command push is accepted if the FIFO is not full, or if it is full and a pop (`cmd_valid_o & cmd_ready_i`) occurs in the same cycle. Otherwise the word is dropped and `cmd_overflow` is set.
- The command FIFO is show-ahead: `cmd_is_op_o`/`cmd_data_o` are driven from the head entry and hold their value while `cmd_ready_i`=0.
- Result push occurs when `res_valid_i & res_ready_o`. `res_ready_o` = count<RES_DEPTH; it has no combinational dependence on bus reads.
- Read decode (combinational):
  - STATUS: [7:0] cmd_count, [15:8] res_count, [16] cmd_full, [17] res_empty, [24] cmd_overflow, [25] res_underflow, others 0.
  - RESULT: returns the head word, or 0 if empty.
  - Unmapped addresses return 0.
- RESULT read with `wb_read_req`=1 pops the head. If the FIFO is empty, no pop occurs and `res_underflow` is set. A held strobe pops once per cycle.
- Pointers wrap modulo depth. Counts are log2(depth)+1 bits, zero-extended into their 8-bit fields.
- If a sticky-bit set and a W1C clear hit in the same cycle, set wins.

## Timing
- Reset (async assert, sync-safe release) clears pointers, counts, `wr_q`, and sticky bits. Reset values: `cmd_valid_o`=0, `cmd_is_op_o`=0, `cmd_data_o`=0, `res_ready_o`=1, `wishbone_output`=0 (0x0002_0000 if STATUS is addressed).
- Reset mid-operation discards all queued entries and any pending `wr_q` write.
- Bus write at cycle N (`wb_write_req`): decoded in N+1; `cmd_valid_o` rises in N+2 if the FIFO was empty.
- Bus read: data is valid in the `wb_read_req` cycle. The pop takes effect at the closing edge, so the next read returns the next entry.
- Core-side result push at edge E is visible to a RESULT read from cycle E+1.

## Configuration
- `WB_CMD_QUEUE_ERR_EN` defined: sticky `cmd_overflow`/`res_underflow` bits are implemented, reported in STATUS, and cleared by W1C.
- Not defined: no sticky bits; STATUS[25:24] read 0 and W1C writes are ignored. Drop/no-pop behaviour is unchanged.

## Test plan
- Reset, then read STATUS: returns 0x0002_0000. `res_ready_o`=1 and `cmd_valid_o`=0.
- Write OPCODE 0xA5 then OPERAND 0x1234 with `cmd_ready_i`=0: `cmd_valid_o`=1 two cycles after the first strobe. Head is {1,0xA5}; after one ready cycle, head is {0,0x1234}.
- With `cmd_ready_i`=0, write 9 words at CMD_DEPTH=8: cmd_count=8, cmd_full=1, 9th word dropped, STATUS[24]=1. Writing 0x0100_0000 to STATUS clears the bit.
- Core pushes 0x11, 0x22 and bus reads RESULT twice: returns 0x11 then 0x22, and res_count goes 2→1→0. A third read returns 0 and sets STATUS[25]=1.
- With the command FIFO full, a push and a pop in the same cycle: push accepted, count stays 8, no overflow.
- Assert `wb_rst_ni`=0 asynchronously with 3 commands queued: `cmd_valid_o` drops immediately. After release, STATUS=0x0002_0000.
